// File: rtl/apb_master_pkg.sv
// Shared types for the APB initiator: FSM encoding, default bus widths and
// a request bundle that command sources can reuse.
package apb_master_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_mst_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic                      write;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired flags the last permitted wait cycle.
// A TIMEOUT of 0 disables expiry entirely.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating: once at all-ones the count holds rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (cnt == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_interface.sv
// APB3 initiator: turns a single-outstanding request/response handshake into
// SETUP/ACCESS transfers, aborting with an error if the target never responds.
module apb_master_interface
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  apb_pclk_i,
  input  logic                  apb_presetn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] apb_paddr_o,
  output logic                  apb_pwrite_o,
  output logic [DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  input  logic                  apb_pready_i,
  input  logic [DATA_WIDTH-1:0] apb_prdata_i
);

  apb_mst_state_e state_q, state_d;
  logic           accept;
  logic           expired;
  logic           psel_d, penable_d;

  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pready is tested before expiry so a response on the limit cycle completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb_pready_i || expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // psel/penable are registered from the next state so they line up with it.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      apb_psel_o    <= 1'b0;
      apb_penable_o <= 1'b0;
      apb_paddr_o   <= '0;
      apb_pwrite_o  <= 1'b0;
      apb_pwdata_o  <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
    end else begin
      apb_psel_o    <= psel_d;
      apb_penable_o <= penable_d;
      rsp_valid_o   <= 1'b0;
      if (accept) begin
        apb_paddr_o  <= req_addr_i;
        apb_pwrite_o <= req_write_i;
        apb_pwdata_o <= req_wdata_i;
      end
      if (state_q == ACCESS) begin
        if (apb_pready_i) begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= apb_pwrite_o ? '0 : apb_prdata_i;
        end else if (expired) begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b1;
          rsp_rdata_o <= '0;
        end
      end
    end
  end

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (apb_pclk_i),
    .rst_n   (apb_presetn_i),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !apb_pready_i),
    .expired (expired)
  );

endmodule

// File: tb/tb_apb_master_interface.sv
// Directed bench for apb_master_interface with TIMEOUT = 4; the bench plays the
// APB target cycle by cycle and checks every output against hand-derived values.
module tb_apb_master_interface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] paddr;
  logic        pwrite, psel, penable, pready;
  logic [31:0] pwdata, prdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [11:0] ba [3] = '{12'h100, 12'h104, 12'h108};
  logic [31:0] bd [3] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};

  apb_master_interface #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .apb_pclk_i    (clk),
    .apb_presetn_i (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_write_i   (req_write),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .apb_paddr_o   (paddr),
    .apb_pwrite_o  (pwrite),
    .apb_pwdata_o  (pwdata),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_pready_i  (pready),
    .apb_prdata_i  (prdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [11:0] a, input logic w, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    tick; tick;
    check("rst_psel",    32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_paddr",   32'(paddr), 0);
    check("rst_pwdata",  pwdata, 0);
    check("rst_rsp_vld", 32'(rsp_valid), 0);
    check("rst_rdata",   rsp_rdata, 0);
    check("rst_err",     32'(rsp_err), 0);
    check("rst_ready",   32'(req_ready), 1);
    req(12'h004, 1'b1, 32'h0000_0001);
    tick;
    check("rst_no_accept", 32'(psel), 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick;

    // zero-wait write
    req(12'h004, 1'b1, 32'hDEAD_BEEF);
    check("wr_ready", 32'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    check("wr_setup_psel",  32'(psel), 1);
    check("wr_setup_pen",   32'(penable), 0);
    check("wr_setup_addr",  32'(paddr), 32'h004);
    check("wr_setup_write", 32'(pwrite), 1);
    check("wr_setup_wdata", pwdata, 32'hDEAD_BEEF);
    check("wr_setup_ready", 32'(req_ready), 0);
    tick;
    check("wr_acc_psel",  32'(psel), 1);
    check("wr_acc_pen",   32'(penable), 1);
    check("wr_acc_addr",  32'(paddr), 32'h004);
    check("wr_acc_wdata", pwdata, 32'hDEAD_BEEF);
    check("wr_acc_vld",   32'(rsp_valid), 0);
    pready = 1'b1; prdata = 32'h1234_5678;
    tick;
    pready = 1'b0;
    check("wr_rsp_vld",   32'(rsp_valid), 1);
    check("wr_rsp_err",   32'(rsp_err), 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_end_psel",  32'(psel), 0);
    check("wr_end_pen",   32'(penable), 0);
    check("wr_end_ready", 32'(req_ready), 1);
    check("wr_hold_addr", 32'(paddr), 32'h004);
    tick;
    check("wr_pulse_1cyc", 32'(rsp_valid), 0);

    // read against registered-pready front-end: ACCESS lasts 2 cycles
    req(12'h010, 1'b0, 32'h0);
    tick;
    req_valid = 1'b0;
    check("rd_setup_write", 32'(pwrite), 0);
    tick;
    check("rd_acc1_pen",   32'(penable), 1);
    check("rd_acc1_ready", 32'(req_ready), 0);
    tick;
    check("rd_acc2_pen", 32'(penable), 1);
    check("rd_acc2_vld", 32'(rsp_valid), 0);
    pready = 1'b1; prdata = 32'h0000_A5A5;
    tick;
    pready = 1'b0; prdata = '0;
    check("rd_rsp_vld",   32'(rsp_valid), 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h0000_A5A5);
    check("rd_rsp_err",   32'(rsp_err), 0);
    check("rd_ready_4",   32'(req_ready), 1);
    tick;
    check("rd_rdata_hold", rsp_rdata, 32'h0000_A5A5);

    // timeout: no pready, exactly 4 ACCESS cycles
    req(12'h020, 1'b0, 32'h0);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("to_acc%0d_pen", i), 32'(penable), 1);
      check($sformatf("to_acc%0d_vld", i), 32'(rsp_valid), 0);
    end
    tick;
    check("to_psel_drop", 32'(psel), 0);
    check("to_rsp_vld",   32'(rsp_valid), 1);
    check("to_rsp_err",   32'(rsp_err), 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    tick;
    check("to_err_hold", 32'(rsp_err), 1);

    // pready on the 4th ACCESS cycle beats the timeout
    req(12'h030, 1'b0, 32'h0);
    tick;
    req_valid = 1'b0;
    tick; tick; tick; tick;
    check("lim_acc4_pen", 32'(penable), 1);
    pready = 1'b1; prdata = 32'hCAFE_0001;
    tick;
    pready = 1'b0; prdata = '0;
    check("lim_rsp_vld",   32'(rsp_valid), 1);
    check("lim_rsp_err",   32'(rsp_err), 0);
    check("lim_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    tick;

    // back-to-back with req_valid held high
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        check($sformatf("b2b%0d_vld", k - 1), 32'(rsp_valid), 1);
        check($sformatf("b2b%0d_rdata", k - 1), rsp_rdata, bd[k-1]);
      end
      check($sformatf("b2b%0d_ready", k), 32'(req_ready), 1);
      req(ba[k], 1'b0, 32'h0);
      pready = 1'b0;
      tick;
      check($sformatf("b2b%0d_addr", k), 32'(paddr), 32'(ba[k]));
      check($sformatf("b2b%0d_setup", k), 32'(penable), 0);
      if (k == 2) req_valid = 1'b0;
      tick;
      check($sformatf("b2b%0d_acc", k), 32'(penable), 1);
      pready = 1'b1; prdata = bd[k];
      tick;
    end
    pready = 1'b0; prdata = '0;
    check("b2b2_vld",   32'(rsp_valid), 1);
    check("b2b2_rdata", rsp_rdata, bd[2]);
    tick;
    check("b2b_end_vld",  32'(rsp_valid), 0);
    check("b2b_end_psel", 32'(psel), 0);

    // asynchronous reset during ACCESS
    req(12'h040, 1'b1, 32'h0000_0055);
    tick;
    req_valid = 1'b0;
    tick;
    check("ar_acc_pen", 32'(penable), 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_psel",  32'(psel), 0);
    check("ar_pen",   32'(penable), 0);
    check("ar_vld",   32'(rsp_valid), 0);
    check("ar_paddr", 32'(paddr), 0);
    tick; tick;
    check("ar_hold_vld", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    tick;
    check("ar_rel_vld",   32'(rsp_valid), 0);
    check("ar_rel_ready", 32'(req_ready), 1);
    req(12'h044, 1'b1, 32'h0000_0077);
    tick;
    req_valid = 1'b0;
    check("ar_new_addr", 32'(paddr), 32'h044);
    check("ar_new_psel", 32'(psel), 1);
    tick;
    pready = 1'b1;
    tick;
    pready = 1'b0;
    check("ar_new_vld", 32'(rsp_valid), 1);
    check("ar_new_err", 32'(rsp_err), 0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
